// File: rtl/bcd_alu_sequencer_if.sv
// Request/result bundle between entry control and the BCD arithmetic sequencer.
// The master side issues operations; the slave side returns the sign-magnitude result and flags.
interface bcd_alu_sequencer_if #(
    parameter int unsigned DIGIT_NUM = 8
);
    logic                     start;
    logic [2:0]               operation;
    logic [4*DIGIT_NUM-1:0]   operand0;
    logic                     operand0_sign;
    logic [4*DIGIT_NUM-1:0]   operand1;
    logic                     operand1_sign;
    logic                     busy;
    logic                     done;
    logic [4*DIGIT_NUM-1:0]   result;
    logic                     flag_sign;
    logic                     flag_ov;
    logic                     flag_err;

    modport master (
        output start, operation, operand0, operand0_sign, operand1, operand1_sign,
        input  busy, done, result, flag_sign, flag_ov, flag_err
    );

    modport slave (
        input  start, operation, operand0, operand0_sign, operand1, operand1_sign,
        output busy, done, result, flag_sign, flag_ov, flag_err
    );
endinterface

// File: rtl/bcd_alu_sequencer.sv
// Signed BCD arithmetic sequencer: single-cycle SUM/SUB, digit-serial MUL and DIV built
// from one shared (DIGIT_NUM+1)-digit BCD adder and subtractor.
module bcd_alu_sequencer #(
    parameter int unsigned DIGIT_NUM = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_alu_sequencer_if.slave   bus
);
    localparam int unsigned W    = 4 * DIGIT_NUM;
    localparam int unsigned W1   = W + 4;
    localparam int unsigned IdxW = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;

    localparam logic [2:0] OpSum = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b010;
    localparam logic [2:0] OpDiv = 3'b011;

    typedef enum logic [2:0] {
        StIdle, StExec, StMulShift, StMulAdd, StDivShift, StDivSub, StDone
    } state_e;

    function automatic logic [W1-1:0] bcd_add(input logic [W1-1:0] a, input logic [W1-1:0] b);
        logic [W1-1:0] s;
        logic          c;
        logic [4:0]    t;
        logic [4:0]    t2;
        s = '0;
        c = 1'b0;
        for (int i = 0; i <= int'(DIGIT_NUM); i++) begin
            t  = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            t2 = t - 5'd10;
            if (t > 5'd9) begin
                s[4*i +: 4] = t2[3:0];
                c = 1'b1;
            end else begin
                s[4*i +: 4] = t[3:0];
                c = 1'b0;
            end
        end
        return s;
    endfunction

    // Returns {borrow, difference}.
    function automatic logic [W1:0] bcd_sub(input logic [W1-1:0] a, input logic [W1-1:0] b);
        logic [W1-1:0] d;
        logic          br;
        logic [4:0]    t;
        logic [4:0]    t2;
        d  = '0;
        br = 1'b0;
        for (int i = 0; i <= int'(DIGIT_NUM); i++) begin
            t  = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, br};
            t2 = t + 5'd10;
            if (t[4]) begin
                d[4*i +: 4] = t2[3:0];
                br = 1'b1;
            end else begin
                d[4*i +: 4] = t[3:0];
                br = 1'b0;
            end
        end
        return {br, d};
    endfunction

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            s0_q, s0_d;
    logic            s1_q, s1_d;
    logic [W1-1:0]   work_q, work_d;
    logic [W-1:0]    quot_q, quot_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            ovs_q, ovs_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    result_q, result_d;
    logic            sign_q, sign_d;
    logic            ov_q, ov_d;
    logic            err_q, err_d;

    logic [W1-1:0]   add_a, add_b, add_res;
    logic [W1-1:0]   sub_a, sub_b;
    logic [W1:0]     sub_res;
    logic            swap;
    logic            eff_s1;
    logic [W-1:0]    mag;
    logic [3:0]      digit;
    logic            fin_mul, fin_div;

    // Magnitude compare is valid on BCD directly since every digit is <= 9.
    assign swap = (b_q > a_q);

    always_comb begin
        add_a = '0;
        add_b = '0;
        sub_a = '0;
        sub_b = '0;
        case (state_q)
            StExec: begin
                add_a = {4'h0, a_q};
                add_b = {4'h0, b_q};
                sub_a = swap ? {4'h0, b_q} : {4'h0, a_q};
                sub_b = swap ? {4'h0, a_q} : {4'h0, b_q};
            end
            StMulAdd: begin
                add_a = {4'h0, work_q[W-1:0]};
                add_b = {4'h0, a_q};
            end
            StDivSub: begin
                sub_a = work_q;
                sub_b = {4'h0, b_q};
                add_a = {4'h0, quot_q};
                add_b = W1'(1);
            end
            default: ;
        endcase
    end

    assign add_res = bcd_add(add_a, add_b);
    assign sub_res = bcd_sub(sub_a, sub_b);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        work_d   = work_q;
        quot_d   = quot_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ovs_d    = ovs_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        sign_d   = sign_q;
        ov_d     = ov_q;
        err_d    = err_q;
        eff_s1   = 1'b0;
        mag      = '0;
        digit    = '0;
        fin_mul  = 1'b0;
        fin_div  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d     = bus.operation;
                    a_d      = bus.operand0;
                    b_d      = bus.operand1;
                    s0_d     = bus.operand0_sign;
                    s1_d     = bus.operand1_sign;
                    work_d   = '0;
                    quot_d   = '0;
                    ovs_d    = 1'b0;
                    idx_d    = IdxW'(DIGIT_NUM - 1);
                    busy_d   = 1'b1;
                    result_d = '0;
                    sign_d   = 1'b0;
                    ov_d     = 1'b0;
                    err_d    = 1'b0;
                    case (bus.operation)
                        OpMul:   state_d = StMulShift;
                        OpDiv:   state_d = (bus.operand1 == '0) ? StExec : StDivShift;
                        default: state_d = StExec;
                    endcase
                end
            end
            StExec: begin
                case (op_q)
                    OpSum, OpSub: begin
                        eff_s1 = s1_q ^ (op_q == OpSub);
                        if (s0_q == eff_s1) begin
                            mag    = add_res[W-1:0];
                            ov_d   = (add_res[W1-1 -: 4] != 4'h0);
                            sign_d = s0_q & (mag != '0);
                        end else begin
                            mag    = sub_res[W-1:0];
                            ov_d   = 1'b0;
                            sign_d = (s0_q ^ swap) & (mag != '0);
                        end
                        result_d = mag;
                        err_d    = 1'b0;
                    end
                    default: begin
                        // Divide by zero, EXP and reserved codes all land here.
                        result_d = '0;
                        sign_d   = 1'b0;
                        ov_d     = 1'b0;
                        err_d    = 1'b1;
                    end
                endcase
                state_d = StDone;
                done_d  = 1'b1;
            end
            StMulShift: begin
                digit  = b_q[{idx_q, 2'b00} +: 4];
                work_d = {4'h0, work_q[W-5:0], 4'h0};
                ovs_d  = ovs_q | (work_q[W-1 -: 4] != 4'h0);
                cnt_d  = digit;
                if (digit != 4'h0) begin
                    state_d = StMulAdd;
                end else if (idx_q == '0) begin
                    fin_mul = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StMulAdd: begin
                work_d = {4'h0, add_res[W-1:0]};
                ovs_d  = ovs_q | (add_res[W1-1 -: 4] != 4'h0);
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (idx_q == '0) begin
                        fin_mul = 1'b1;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = StMulShift;
                    end
                end
            end
            StDivShift: begin
                digit   = a_q[{idx_q, 2'b00} +: 4];
                work_d  = {work_q[W-1:0], digit};
                quot_d  = {quot_q[W-5:0], 4'h0};
                state_d = StDivSub;
            end
            StDivSub: begin
                if (!sub_res[W1]) begin
                    work_d = sub_res[W1-1:0];
                    quot_d = add_res[W-1:0];
                end else if (idx_q == '0) begin
                    fin_div = 1'b1;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = StDivShift;
                end
            end
            StDone: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (fin_mul) begin
            state_d  = StDone;
            done_d   = 1'b1;
            result_d = work_d[W-1:0];
            ov_d     = ovs_d;
            sign_d   = (s0_q ^ s1_q) & (work_d[W-1:0] != '0);
            err_d    = 1'b0;
        end
        if (fin_div) begin
            state_d  = StDone;
            done_d   = 1'b1;
            result_d = quot_q;
            ov_d     = 1'b0;
            sign_d   = (s0_q ^ s1_q) & (quot_q != '0);
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            work_q   <= '0;
            quot_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            ovs_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            sign_q   <= 1'b0;
            ov_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            work_q   <= work_d;
            quot_q   <= quot_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ovs_q    <= ovs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            ov_q     <= ov_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.flag_sign = sign_q;
    assign bus.flag_ov   = ov_q;
    assign bus.flag_err  = err_q;
endmodule

// File: tb/tb_bcd_alu_sequencer.sv
// Scoreboard bench for bcd_alu_sequencer: an integer reference model predicts result, flags and
// done latency at issue time; a monitor pops and compares on every done pulse.
module tb_bcd_alu_sequencer;
    localparam int unsigned DIGIT_NUM = 8;
    localparam longint      Lim       = 100000000;

    typedef struct {
        logic [31:0] result;
        logic        sign;
        logic        ov;
        logic        err;
        int unsigned lat;
        int unsigned start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_alu_sequencer_if #(.DIGIT_NUM(DIGIT_NUM)) bus ();

    bcd_alu_sequencer #(.DIGIT_NUM(DIGIT_NUM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb_q[$];
    int unsigned n_tests  = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned done_cnt = 0;
    int unsigned exp_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint bcd2int(input logic [31:0] v);
        longint r = 0;
        for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input longint v);
        logic [31:0] r;
        longint      t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int unsigned dsum(input logic [31:0] v);
        int unsigned s = 0;
        for (int i = 0; i < 8; i++) s += int'(v[4*i +: 4]);
        return s;
    endfunction

    function automatic logic [31:0] rand_bcd(input int nd);
        logic [31:0] r = '0;
        for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic sa,
                                   input logic [31:0] b, input logic sb);
        exp_t   e;
        longint ma = bcd2int(a);
        longint mb = bcd2int(b);
        longint r;
        longint mag;
        e.result = '0; e.sign = 1'b0; e.ov = 1'b0; e.err = 1'b0; e.lat = 2; e.start_cyc = 0;
        case (op)
            3'd0, 3'd1: begin
                r   = (sa ? -ma : ma) + ((sb ^ (op == 3'd1)) ? -mb : mb);
                mag = (r < 0) ? -r : r;
                e.ov     = (mag >= Lim);
                e.result = int2bcd(mag % Lim);
                e.sign   = (r < 0) && ((mag % Lim) != 0);
            end
            3'd2: begin
                mag      = ma * mb;
                e.ov     = (mag >= Lim);
                e.result = int2bcd(mag % Lim);
                e.sign   = (sa ^ sb) && ((mag % Lim) != 0);
                e.lat    = DIGIT_NUM + dsum(b) + 1;
            end
            3'd3: begin
                if (mb == 0) begin
                    e.err = 1'b1;
                end else begin
                    mag      = ma / mb;
                    e.result = int2bcd(mag);
                    e.sign   = (sa ^ sb) && (mag != 0);
                    e.lat    = 2 * DIGIT_NUM + dsum(int2bcd(mag)) + 1;
                end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.done) begin
            done_cnt++;
            check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("result", 64'(bus.result), 64'(e.result));
                check_eq("sign", 64'(bus.flag_sign), 64'(e.sign));
                check_eq("ov", 64'(bus.flag_ov), 64'(e.ov));
                check_eq("err", 64'(bus.flag_err), 64'(e.err));
                check_eq("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic sa,
                         input logic [31:0] b, input logic sb);
        bus.operation     = op;
        bus.operand0      = a;
        bus.operand0_sign = sa;
        bus.operand1      = b;
        bus.operand1_sign = sb;
        bus.start         = 1'b1;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic sa,
                            input logic [31:0] b, input logic sb);
        exp_t e;
        e = model(op, a, sa, b, sb);
        @(posedge clk);
        #1;
        drive(op, a, sa, b, sb);
        e.start_cyc = cyc;
        sb_q.push_back(e);
        exp_done++;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("busy_after_accept", 64'(bus.busy), 64'd1);
        check_eq("result_cleared", 64'(bus.result), 64'd0);
    endtask

    task automatic wait_done();
        logic got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("done_seen", 64'(got), 64'd1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic sa,
                          input logic [31:0] b, input logic sb);
        start_op(op, a, sa, b, sb);
        wait_done();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] ra, rb;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.operation = '0;
        bus.operand0 = '0;
        bus.operand0_sign = 1'b0;
        bus.operand1 = '0;
        bus.operand1_sign = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_result", 64'(bus.result), 64'd0);
        check_eq("rst_sign", 64'(bus.flag_sign), 64'd0);
        check_eq("rst_ov", 64'(bus.flag_ov), 64'd0);
        check_eq("rst_err", 64'(bus.flag_err), 64'd0);

        run_op(3'd0, 32'h00000123, 1'b0, 32'h00000456, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("result_held", 64'(bus.result), 64'h333);
        check_eq("busy_idle", 64'(bus.busy), 64'd0);
        run_op(3'd0, 32'h99999999, 1'b0, 32'h00000001, 1'b0);
        run_op(3'd1, 32'h00000005, 1'b0, 32'h00000005, 1'b0);
        run_op(3'd1, 32'h00000010, 1'b1, 32'h00000003, 1'b1);
        run_op(3'd0, 32'h99999999, 1'b1, 32'h00000001, 1'b1);
        run_op(3'd2, 32'h00001234, 1'b1, 32'h00000056, 1'b0);
        run_op(3'd2, 32'h00004321, 1'b1, 32'h00000000, 1'b0);
        run_op(3'd2, 32'h00100000, 1'b0, 32'h00001000, 1'b0);
        run_op(3'd2, 32'h99999999, 1'b0, 32'h00000001, 1'b0);
        run_op(3'd3, 32'h00000100, 1'b0, 32'h00000007, 1'b1);
        run_op(3'd3, 32'h00000100, 1'b1, 32'h00000000, 1'b0);
        run_op(3'd3, 32'h00000003, 1'b1, 32'h00000007, 1'b0);
        run_op(3'd4, 32'h00000002, 1'b0, 32'h00000003, 1'b0);
        run_op(3'd7, 32'h00000002, 1'b1, 32'h00000003, 1'b0);

        for (int k = 0; k < 6; k++) begin
            ra = rand_bcd(8);
            rb = rand_bcd($urandom_range(1, 8));
            run_op(3'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), rb,
                   1'($urandom_range(0, 1)));
            run_op(3'd2, rand_bcd($urandom_range(1, 8)), 1'($urandom_range(0, 1)),
                   rand_bcd($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
            rb = rand_bcd($urandom_range(1, 4));
            if (rb == 32'h0) rb = 32'h00000007;
            run_op(3'd3, rand_bcd(8), 1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 1)));
        end

        // start pulses while busy and during the done cycle must be ignored
        start_op(3'd2, 32'h00001234, 1'b0, 32'h00000056, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        drive(3'd0, 32'h00000001, 1'b0, 32'h00000001, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();
        drive(3'd0, 32'h00000002, 1'b0, 32'h00000002, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("ignored_start_dones", 64'(done_cnt), 64'(exp_done));
        check_eq("ignored_start_busy", 64'(bus.busy), 64'd0);
        check_eq("ignored_start_result", 64'(bus.result), 64'h69104);

        // reset in the middle of a long multiply
        start_op(3'd2, 32'h99999999, 1'b1, 32'h00000099, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        exp_done--;
        check_eq("midrst_busy", 64'(bus.busy), 64'd0);
        check_eq("midrst_done", 64'(bus.done), 64'd0);
        check_eq("midrst_result", 64'(bus.result), 64'd0);
        check_eq("midrst_flags", 64'({bus.flag_sign, bus.flag_ov, bus.flag_err}), 64'd0);
        repeat (40) @(negedge clk);
        check_eq("midrst_no_done", 64'(done_cnt), 64'(exp_done));
        run_op(3'd2, 32'h00000012, 1'b0, 32'h00000034, 1'b1);

        repeat (5) @(negedge clk);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        check_eq("done_total", 64'(done_cnt), 64'(exp_done));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
